glitch_pulse_gen: RTL and testbench
===================================

# glitch_pulse_gen

Consumer of the operator-adjusted 32-bit delay and width registers: waits for an external target trigger edge, counts a programmed delay, then drives a single glitch pulse of programmed width on `glitch_out`. It sits between the button-driven value registers and the glitch output pin. It arms on an operator arm-button edge and re-arms only after a holdoff, so one arm yields at most one shot.

## Interface
- `HOLDOFF`, default 16: cycles spent in HOLDOFF after each shot before returning to IDLE; must be ≥1.
- `clk` in 1: single system clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `arm` in 1: operator arm request (button level); its rising edge is used.
- `abort` in 1: synchronous level; cancels any operation.
- `trigger` in 1: asynchronous target trigger; 2-flop synchronized internally.
- `trig_pol` in 1: 1 = rising-edge trigger, 0 = falling; latched on arm.
- `delay` in 32: trigger-to-pulse delay in clk cycles; latched on arm.
- `pulse_width` in 32: glitch width in clk cycles; latched on arm.
- `glitch_out` out 1: registered glitch pulse.
- `armed` out 1: high while in ARMED.
- `busy` out 1: high in DELAY, PULSE or HOLDOFF.
- `done` out 1: one-cycle pulse at shot completion.
- `shot_count` out 16: completed shots; wraps 0xFFFF→0.

## Operation
- Reset (`rst_n`=0 at a posedge): state IDLE; `glitch_out`, `armed`, `busy`, `done` = 0; `shot_count` = 0; synchronizer and edge-history flops = 0; latched delay, width and polarity = 0. Reset mid-pulse drops `glitch_out` at that edge.
- `arm` edge: `arm_q` registers `arm`; arm_edge = `arm` & ~`arm_q`.
- Trigger path: s1←`trigger`, s2←s1, s3←s2. trig_edge = pol_l ? (s2 & ~s3) : (~s2 & s3). A level already present at arm time never fires; only a transition fires.
- States:
  - IDLE: on arm_edge, latch `delay`→D, `pulse_width`→W, `trig_pol`→pol_l; go to ARMED.
  - ARMED: on trig_edge, load cnt=D. If D==0, go to PULSE (or DONE-path if W==0); otherwise go to DELAY.
  - DELAY: decrement cnt. When cnt reaches 1, go to PULSE with cnt=W, or complete directly if W==0.
  - PULSE: `glitch_out`=1; decrement cnt. When cnt reaches 1, clear `glitch_out`, pulse `done`, go to HOLDOFF with cnt=HOLDOFF.
  - HOLDOFF: decrement cnt; on reaching 1, return to IDLE.
- W==0: no pulse; `done` still fires at the cycle the pulse would have started; then HOLDOFF.
- `abort`=1 in any state: next edge goes to IDLE, `glitch_out`=0, no `done`, no count increment. Abort beats a same-cycle arm_edge or trig_edge.
- arm_edge outside IDLE is ignored. Input `delay`, `pulse_width` and `trig_pol` changes after arm have no effect on the current shot.
- `shot_count` increments by 1 on each `done`. 16-bit wrap, no saturation.
- Counters are 32-bit unsigned. D and W up to 0xFFFFFFFF must work exactly, with no overflow.

## Timing
- Let N = first posedge sampling the new trigger level while ARMED. trig_edge is true in the cycle after edge N+1; the FSM leaves ARMED at edge N+2.
- `glitch_out` rises at edge N+2+D and falls at edge N+2+D+W, giving exactly W cycles high.
- `done` is high for exactly one cycle, starting at edge N+2+D+W.
- `busy` is high from edge N+2 until HOLDOFF cycles after `done` rises. `armed` falls at edge N+2.
- The arm button rises at edge A. `armed`=1 from edge A+1.
- A minimum trigger pulse of 2 cycles is guaranteed to be detected.

## Test plan
- Reset, then trig_pol=1, D=5, W=3, arm; raise `trigger` at edge N. Required: `glitch_out` high on edges N+7..N+9, low at N+10. `done` is a single cycle at N+10. `shot_count`=1.
- D=0, W=1, trig_pol=0, `trigger` held high before arm, then dropped. Required: 1-cycle pulse at N+2. Holding high at arm time alone produces nothing.
- W=0, D=4. Required: `glitch_out` never rises; `done` at N+6; `shot_count` increments.
- Assert `abort` 2 cycles into PULSE (D=2, W=10). Required: `glitch_out` low the next edge; IDLE; no `done`; `shot_count` unchanged.
- Pulse `arm` while in DELAY, and change `delay` to 100 after arm (latched D=5). Required: shot still at N+7; no re-arm until HOLDOFF completes.
- Preload via 65535 shots, or force `shot_count`=0xFFFF, then fire once. Required: `shot_count`=0. Also apply reset mid-DELAY. Required: all outputs 0 at that edge, and a later trigger edge fires nothing until re-armed.

Source files
------------

// File: rtl/glitch_pulse_gen.sv
// rtl/glitch_pulse_gen.sv - armed one-shot glitch generator: trigger edge, programmed delay, programmed pulse width, holdoff
module glitch_pulse_gen #(
    parameter int unsigned HOLDOFF = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        abort,
    input  logic        trigger,
    input  logic        trig_pol,
    input  logic [31:0] delay,
    input  logic [31:0] pulse_width,
    output logic        glitch_out,
    output logic        armed,
    output logic        busy,
    output logic        done,
    output logic [15:0] shot_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    localparam logic [31:0] HOLDOFF_CNT = 32'(HOLDOFF);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] d_l, d_n;
    logic [31:0] w_l, w_n;
    logic        pol_l, pol_n;
    logic        glitch_q, glitch_n;
    logic        done_q, done_n;
    logic [15:0] shot_cnt_q, shot_n;
    logic        arm_q;
    logic        s1, s2, s3;
    logic        arm_edge;
    logic        trig_edge;

    assign arm_edge  = arm & ~arm_q;
    assign trig_edge = pol_l ? (s2 & ~s3) : (~s2 & s3);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        d_n      = d_l;
        w_n      = w_l;
        pol_n    = pol_l;
        glitch_n = 1'b0;
        done_n   = 1'b0;
        shot_n   = shot_cnt_q;
        case (state)
            S_IDLE: begin
                if (arm_edge) begin
                    d_n     = delay;
                    w_n     = pulse_width;
                    pol_n   = trig_pol;
                    state_n = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_edge) begin
                    if (d_l != 32'd0) begin
                        cnt_n   = d_l;
                        state_n = S_DELAY;
                    end else if (w_l != 32'd0) begin
                        cnt_n    = w_l;
                        glitch_n = 1'b1;
                        state_n  = S_PULSE;
                    end else begin
                        done_n  = 1'b1;
                        cnt_n   = HOLDOFF_CNT;
                        state_n = S_HOLDOFF;
                    end
                end
            end
            S_DELAY: begin
                if (cnt != 32'd1) begin
                    cnt_n = cnt - 32'd1;
                end else if (w_l != 32'd0) begin
                    cnt_n    = w_l;
                    glitch_n = 1'b1;
                    state_n  = S_PULSE;
                end else begin
                    // zero width: report completion where the pulse would have begun
                    done_n  = 1'b1;
                    cnt_n   = HOLDOFF_CNT;
                    state_n = S_HOLDOFF;
                end
            end
            S_PULSE: begin
                if (cnt != 32'd1) begin
                    cnt_n    = cnt - 32'd1;
                    glitch_n = 1'b1;
                end else begin
                    done_n  = 1'b1;
                    cnt_n   = HOLDOFF_CNT;
                    state_n = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (cnt != 32'd1) begin
                    cnt_n = cnt - 32'd1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (done_n) begin
            shot_n = shot_cnt_q + 16'd1;
        end
        // abort overrides everything decided above, including a same-cycle arm or trigger
        if (abort) begin
            state_n  = S_IDLE;
            glitch_n = 1'b0;
            done_n   = 1'b0;
            shot_n   = shot_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 32'd0;
            d_l        <= 32'd0;
            w_l        <= 32'd0;
            pol_l      <= 1'b0;
            glitch_q   <= 1'b0;
            done_q     <= 1'b0;
            shot_cnt_q <= 16'd0;
            arm_q      <= 1'b0;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            d_l        <= d_n;
            w_l        <= w_n;
            pol_l      <= pol_n;
            glitch_q   <= glitch_n;
            done_q     <= done_n;
            shot_cnt_q <= shot_n;
            arm_q      <= arm;
            s1         <= trigger;
            s2         <= s1;
            s3         <= s2;
        end
    end

    assign glitch_out = glitch_q;
    assign done       = done_q;
    assign shot_count = shot_cnt_q;
    assign armed      = (state == S_ARMED);
    assign busy       = (state == S_DELAY) || (state == S_PULSE) || (state == S_HOLDOFF);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb/tb_glitch_pulse_gen.sv - scoreboard bench for glitch_pulse_gen
module tb_glitch_pulse_gen;

    localparam int HO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trigger = 1'b0;
    logic        trig_pol = 1'b0;
    logic [31:0] delay = 32'd0;
    logic [31:0] pulse_width = 32'd0;
    logic        glitch_out;
    logic        armed;
    logic        busy;
    logic        done;
    logic [15:0] shot_count;

    glitch_pulse_gen #(.HOLDOFF(HO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .abort      (abort),
        .trigger    (trigger),
        .trig_pol   (trig_pol),
        .delay      (delay),
        .pulse_width(pulse_width),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done),
        .shot_count (shot_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        int          rise_cyc;
        logic [15:0] shots;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          allow_stray = 1'b0;
    bit          rise_seen = 1'b0;
    int          rise_obs = -1;
    logic        g_prev = 1'b0;
    logic [15:0] exp_shots = 16'd0;
    int          n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_arm(input logic pol, input logic [31:0] d, input logic [31:0] w);
        @(negedge clk);
        trig_pol    = pol;
        delay       = d;
        pulse_width = w;
        arm         = 1'b1;
        @(negedge clk);
        chk("armed_after_arm", armed, 1'b1);
        arm = 1'b0;
    endtask

    task automatic fire(input logic lvl, output int edge_n);
        @(negedge clk);
        trigger = lvl;
        edge_n  = cyc + 1;
    endtask

    task automatic push(input int edge_n, input int d, input int w);
        exp_t e;
        exp_shots  = exp_shots + 16'd1;
        e.done_cyc = edge_n + 2 + d + w;
        e.rise_cyc = (w == 0) ? -1 : edge_n + 2 + d;
        e.shots    = exp_shots;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // monitor: pulse rises are recorded, each done pops and checks one expected shot
    always @(negedge clk) begin
        if (glitch_out && !g_prev) begin
            rise_obs  = cyc;
            rise_seen = 1'b1;
            if (sb.size() == 0 && !allow_stray) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got rise at cycle %0d expected none", cyc);
            end
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                if (e.rise_cyc < 0) begin
                    chk("no_pulse_for_w0", 64'(rise_seen), 64'd0);
                end else begin
                    chk("pulse_rise_cycle", rise_seen ? 64'(rise_obs) : 64'hFFFF_FFFF, 64'(e.rise_cyc));
                    chk("pulse_low_at_done", 64'(glitch_out), 64'd0);
                end
                chk("shot_count_at_done", 64'(shot_count), 64'(e.shots));
            end
            rise_seen = 1'b0;
        end
        g_prev = glitch_out;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        step(3);
        chk("rst_glitch", glitch_out, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_shots", shot_count, 16'd0);
        rst_n = 1'b1;
        step(2);

        // basic rising-edge shot, D=5 W=3
        do_arm(1'b1, 32'd5, 32'd3);
        fire(1'b1, n);
        push(n, 5, 3);
        wait_cyc(n + 6);
        chk("t1_low_before", glitch_out, 1'b0);
        wait_cyc(n + 9);
        chk("t1_high_last", glitch_out, 1'b1);
        drain(40);
        step(HO + 2);
        chk("t1_idle_busy", busy, 1'b0);

        // falling polarity, D=0 W=1, level present at arm must not fire
        do_arm(1'b0, 32'd0, 32'd1);
        step(6);
        chk("t2_level_no_fire", armed, 1'b1);
        fire(1'b0, n);
        push(n, 0, 1);
        drain(20);
        step(HO + 2);

        // zero width
        do_arm(1'b1, 32'd4, 32'd0);
        fire(1'b1, n);
        push(n, 4, 0);
        drain(30);
        step(HO + 2);

        // abort two cycles into the pulse
        do_arm(1'b0, 32'd2, 32'd10);
        allow_stray = 1'b1;
        fire(1'b0, n);
        wait_cyc(n + 5);
        chk("t4_in_pulse", glitch_out, 1'b1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_abort_glitch", glitch_out, 1'b0);
        chk("t4_abort_busy", busy, 1'b0);
        chk("t4_abort_armed", armed, 1'b0);
        chk("t4_abort_shots", shot_count, exp_shots);
        step(15);
        allow_stray = 1'b0;
        rise_seen   = 1'b0;

        // inputs changed after arm, arm pulses in DELAY and HOLDOFF ignored
        do_arm(1'b1, 32'd5, 32'd2);
        @(negedge clk);
        delay       = 32'd100;
        pulse_width = 32'd50;
        trig_pol    = 1'b0;
        fire(1'b1, n);
        push(n, 5, 2);
        wait_cyc(n + 4);
        arm = 1'b1;
        step(2);
        arm = 1'b0;
        wait_cyc(n + 11);
        arm = 1'b1;
        step(2);
        arm = 1'b0;
        chk("t5_no_rearm_holdoff", armed, 1'b0);
        wait_cyc(n + 9 + HO - 1);
        chk("t5_busy_holdoff", busy, 1'b1);
        step(1);
        chk("t5_busy_end", busy, 1'b0);
        chk("t5_armed_end", armed, 1'b0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // shot counter wrap
        @(negedge clk);
        force dut.shot_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.shot_cnt_q;
        exp_shots = 16'hFFFF;
        chk("t6_preload", shot_count, 16'hFFFF);
        do_arm(1'b0, 32'd1, 32'd1);
        fire(1'b0, n);
        push(n, 1, 1);
        drain(20);
        step(HO + 2);
        chk("t6_wrapped", shot_count, 16'h0000);

        // reset mid-DELAY, later trigger edges must not fire
        do_arm(1'b1, 32'd20, 32'd2);
        fire(1'b1, n);
        wait_cyc(n + 4);
        rst_n = 1'b0;
        step(1);
        chk("t7_rst_glitch", glitch_out, 1'b0);
        chk("t7_rst_armed", armed, 1'b0);
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_done", done, 1'b0);
        chk("t7_rst_shots", shot_count, 16'd0);
        exp_shots = 16'd0;
        rst_n = 1'b1;
        step(2);
        trigger = 1'b0;
        step(4);
        trigger = 1'b1;
        step(40);
        chk("t7_no_fire_armed", armed, 1'b0);
        chk("t7_no_fire_busy", busy, 1'b0);
        do_arm(1'b0, 32'd3, 32'd2);
        fire(1'b0, n);
        push(n, 3, 2);
        drain(30);
        step(HO + 2);
        chk("t7_rearm_shots", shot_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
